// File: rtl/stream_mux_rr.sv
// stream_mux_rr: N-input valid/ready stream multiplexer with one registered output stage.
// Arbitration is packet-aware: once a channel starts a multi-beat packet it owns the output
// until it sends a beat with last=1. Round-robin (RR=1) or fixed lowest-index priority (RR=0).
//
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   in_valid[N]            per-channel valid
//   in_data[N*WIDTH]       channel i at [i*WIDTH +: WIDTH]
//   in_last[N]             per-channel end-of-packet
//   in_ready[N]            per-channel ready (combinational, at most one bit high)
//   out_valid/out_data/out_last/out_sel   registered output beat and its source channel
//   out_ready              consumer ready
module stream_mux_rr #(
   parameter int unsigned N     = 4,
   parameter int unsigned WIDTH = 8,
   parameter int unsigned RR    = 1,
   parameter int unsigned SELW  = $clog2(N)
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [N-1:0]         in_valid,
   input  logic [N*WIDTH-1:0]   in_data,
   input  logic [N-1:0]         in_last,
   output logic [N-1:0]         in_ready,
   output logic                 out_valid,
   output logic [WIDTH-1:0]     out_data,
   output logic                 out_last,
   output logic [SELW-1:0]      out_sel,
   input  logic                 out_ready
);

   // One extra bit so ptr + offset never overflows before the modulo-N fold.
   localparam int unsigned IW = SELW + 1;

   logic                lock;
   logic [SELW-1:0]     lock_ch;
   logic [SELW-1:0]     ptr;

   logic                load_en;
   logic                grant_ok;
   logic [SELW-1:0]     grant;
   logic                xfer;
   logic [WIDTH-1:0]    sel_data;
   logic                sel_last;
   logic [IW-1:0]       idx;
   logic [SELW-1:0]     ptr_next;

   assign load_en = ~out_valid | out_ready;

   // Grant selection from registered lock/ptr state and current in_valid.
   always_comb begin
      grant_ok = 1'b0;
      grant    = '0;
      idx      = '0;
      if (lock) begin
         grant    = lock_ch;
         grant_ok = in_valid[lock_ch];
      end else if (RR != 0) begin
         for (int unsigned k = 0; k < N; k++) begin
            idx = IW'(ptr) + IW'(k);
            if (idx >= IW'(N)) idx = idx - IW'(N);
            if (!grant_ok && in_valid[idx[SELW-1:0]]) begin
               grant_ok = 1'b1;
               grant    = idx[SELW-1:0];
            end
         end
      end else begin
         for (int unsigned k = 0; k < N; k++) begin
            if (!grant_ok && in_valid[k]) begin
               grant_ok = 1'b1;
               grant    = SELW'(k);
            end
         end
      end
   end

   // Payload of the granted channel.
   always_comb begin
      sel_data = '0;
      sel_last = 1'b0;
      for (int unsigned i = 0; i < N; i++) begin
         if (grant == SELW'(i)) begin
            sel_data = in_data[i*WIDTH +: WIDTH];
            sel_last = in_last[i];
         end
      end
   end

   assign xfer     = load_en & grant_ok;
   assign in_ready = xfer ? (N'(1) << grant) : '0;
   assign ptr_next = (grant == SELW'(N - 1)) ? '0 : grant + SELW'(1);

   // Output register, packet lock and round-robin pointer.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_last  <= 1'b0;
         out_sel   <= '0;
         lock      <= 1'b0;
         lock_ch   <= '0;
         ptr       <= '0;
      end else begin
         if (xfer) begin
            out_valid <= 1'b1;
            out_data  <= sel_data;
            out_last  <= sel_last;
            out_sel   <= grant;
            if (sel_last) begin
               lock <= 1'b0;
               ptr  <= ptr_next;
            end else begin
               lock    <= 1'b1;
               lock_ch <= grant;
            end
         end else if (out_ready) begin
            out_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_stream_mux_rr.sv
// Directed testbench for stream_mux_rr: a round-robin instance (dut) and a
// fixed-priority instance (dut_fp) share clock and reset.
module tb_stream_mux_rr;

   logic        clk = 1'b0;
   logic        rst_n;

   logic [3:0]  in_valid, in_last, in_ready;
   logic [31:0] in_data;
   logic        out_valid, out_last, out_ready;
   logic [7:0]  out_data;
   logic [1:0]  out_sel;

   logic [3:0]  in_valid_fp, in_last_fp, in_ready_fp;
   logic [31:0] in_data_fp;
   logic        out_valid_fp, out_last_fp, out_ready_fp;
   logic [7:0]  out_data_fp;
   logic [1:0]  out_sel_fp;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   stream_mux_rr #(.N(4), .WIDTH(8), .RR(1)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_data(in_data), .in_last(in_last), .in_ready(in_ready),
      .out_valid(out_valid), .out_data(out_data), .out_last(out_last), .out_sel(out_sel),
      .out_ready(out_ready)
   );

   stream_mux_rr #(.N(4), .WIDTH(8), .RR(0)) dut_fp (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid_fp), .in_data(in_data_fp), .in_last(in_last_fp), .in_ready(in_ready_fp),
      .out_valid(out_valid_fp), .out_data(out_data_fp), .out_last(out_last_fp), .out_sel(out_sel_fp),
      .out_ready(out_ready_fp)
   );

   task automatic set_data(input int ch, input logic [7:0] v);
      in_data[ch*8 +: 8] = v;
   endtask

   task automatic apply_reset();
      rst_n = 1'b0;
      in_valid = '0; in_last = '0; in_data = '0; out_ready = 1'b1;
      in_valid_fp = '0; in_last_fp = '0; in_data_fp = '0; out_ready_fp = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      in_valid = '0; in_last = '0; in_data = '0; out_ready = 1'b1;
      in_valid_fp = '0; in_last_fp = '0; in_data_fp = '0; out_ready_fp = 1'b1;
      #1;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
      checks++; if (out_data !== 8'h00) begin errors++; $display("FAIL reset_out_data got %h want 00", out_data); end
      checks++; if (out_sel !== 2'd0) begin errors++; $display("FAIL reset_out_sel got %0d want 0", out_sel); end
      checks++; if (out_last !== 1'b0) begin errors++; $display("FAIL reset_out_last got %b want 0", out_last); end
      checks++; if (in_ready !== 4'b0000) begin errors++; $display("FAIL reset_in_ready got %b want 0000", in_ready); end
      @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   task automatic test_single();
      in_valid = 4'b0100; in_last = 4'b0100; set_data(2, 8'hA5); out_ready = 1'b1;
      @(negedge clk);
      checks++; if (in_ready !== 4'b0100) begin errors++; $display("FAIL single_in_ready got %b want 0100", in_ready); end
      @(posedge clk); #1;
      in_valid = '0;
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL single_out_valid got %b want 1", out_valid); end
      checks++; if (out_data !== 8'hA5) begin errors++; $display("FAIL single_out_data got %h want a5", out_data); end
      checks++; if (out_sel !== 2'd2) begin errors++; $display("FAIL single_out_sel got %0d want 2", out_sel); end
      checks++; if (out_last !== 1'b1) begin errors++; $display("FAIL single_out_last got %b want 1", out_last); end
      @(posedge clk); #1;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL single_drain got %b want 0", out_valid); end
   endtask

   task automatic test_round_robin();
      int exp_seq[5] = '{0, 1, 2, 3, 0};
      logic [3:0] exp_rdy;
      apply_reset();
      in_valid = 4'hF; in_last = 4'hF; out_ready = 1'b1;
      for (int c = 0; c < 4; c++) set_data(c, 8'(8'h10 + c));
      for (int k = 0; k < 5; k++) begin
         exp_rdy = 4'b0001 << exp_seq[k];
         @(negedge clk);
         checks++; if (in_ready !== exp_rdy) begin errors++; $display("FAIL rr_in_ready[%0d] got %b want %b", k, in_ready, exp_rdy); end
         @(posedge clk); #1;
         checks++; if (out_valid !== 1'b1 || out_sel !== 2'(exp_seq[k]) || out_data !== 8'(8'h10 + exp_seq[k]))
            begin errors++; $display("FAIL rr_beat[%0d] got v=%b sel=%0d data=%h want v=1 sel=%0d data=%h", k, out_valid, out_sel, out_data, exp_seq[k], 8'(8'h10 + exp_seq[k])); end
      end
      in_valid = '0;
      @(posedge clk); #1;
   endtask

   task automatic test_fixed_priority();
      in_valid_fp = 4'b1010; in_last_fp = 4'b1010; out_ready_fp = 1'b1;
      in_data_fp = 32'h3300_1100;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         checks++; if (in_ready_fp !== 4'b0010) begin errors++; $display("FAIL fp_in_ready[%0d] got %b want 0010", k, in_ready_fp); end
         @(posedge clk); #1;
         checks++; if (out_valid_fp !== 1'b1 || out_sel_fp !== 2'd1 || out_data_fp !== 8'h11)
            begin errors++; $display("FAIL fp_beat[%0d] got v=%b sel=%0d data=%h want v=1 sel=1 data=11", k, out_valid_fp, out_sel_fp, out_data_fp); end
      end
      in_valid_fp = '0;
      @(posedge clk); #1;
   endtask

   task automatic test_packet_lock();
      apply_reset();
      out_ready = 1'b1;
      set_data(1, 8'h11);
      in_valid = 4'b0011; in_last = 4'b0010; set_data(0, 8'hB1);
      @(negedge clk);
      checks++; if (in_ready !== 4'b0001) begin errors++; $display("FAIL lock_b1_ready got %b want 0001", in_ready); end
      @(posedge clk); #1;
      checks++; if (out_sel !== 2'd0 || out_data !== 8'hB1 || out_last !== 1'b0)
         begin errors++; $display("FAIL lock_b1_out got sel=%0d data=%h last=%b want sel=0 data=b1 last=0", out_sel, out_data, out_last); end
      in_valid = 4'b0010;
      for (int k = 0; k < 2; k++) begin
         @(negedge clk);
         checks++; if (in_ready !== 4'b0000) begin errors++; $display("FAIL lock_stall_ready[%0d] got %b want 0000", k, in_ready); end
         @(posedge clk); #1;
      end
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL lock_stall_valid got %b want 0", out_valid); end
      in_valid = 4'b0011; set_data(0, 8'hB2);
      @(negedge clk);
      checks++; if (in_ready !== 4'b0001) begin errors++; $display("FAIL lock_b2_ready got %b want 0001", in_ready); end
      @(posedge clk); #1;
      checks++; if (out_sel !== 2'd0 || out_data !== 8'hB2) begin errors++; $display("FAIL lock_b2_out got sel=%0d data=%h want sel=0 data=b2", out_sel, out_data); end
      in_last = 4'b0011; set_data(0, 8'hB3);
      @(negedge clk);
      checks++; if (in_ready !== 4'b0001) begin errors++; $display("FAIL lock_b3_ready got %b want 0001", in_ready); end
      @(posedge clk); #1;
      checks++; if (out_sel !== 2'd0 || out_data !== 8'hB3 || out_last !== 1'b1)
         begin errors++; $display("FAIL lock_b3_out got sel=%0d data=%h last=%b want sel=0 data=b3 last=1", out_sel, out_data, out_last); end
      in_valid = 4'b0010;
      @(negedge clk);
      checks++; if (in_ready !== 4'b0010) begin errors++; $display("FAIL lock_next_ready got %b want 0010", in_ready); end
      @(posedge clk); #1;
      checks++; if (out_valid !== 1'b1 || out_sel !== 2'd1 || out_data !== 8'h11)
         begin errors++; $display("FAIL lock_next_out got v=%b sel=%0d data=%h want v=1 sel=1 data=11", out_valid, out_sel, out_data); end
      in_valid = '0;
      @(posedge clk); #1;
   endtask

   task automatic test_backpressure();
      out_ready = 1'b1;
      in_valid = 4'b1000; in_last = 4'b1000; set_data(3, 8'h3C);
      @(negedge clk);
      checks++; if (in_ready !== 4'b1000) begin errors++; $display("FAIL bp_first_ready got %b want 1000", in_ready); end
      @(posedge clk); #1;
      out_ready = 1'b0; set_data(3, 8'h3D);
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         checks++; if (in_ready !== 4'b0000) begin errors++; $display("FAIL bp_hold_ready[%0d] got %b want 0000", k, in_ready); end
         checks++; if (out_valid !== 1'b1 || out_data !== 8'h3C || out_sel !== 2'd3)
            begin errors++; $display("FAIL bp_hold_out[%0d] got v=%b data=%h sel=%0d want v=1 data=3c sel=3", k, out_valid, out_data, out_sel); end
         @(posedge clk); #1;
      end
      out_ready = 1'b1;
      @(negedge clk);
      checks++; if (in_ready !== 4'b1000) begin errors++; $display("FAIL bp_release_ready got %b want 1000", in_ready); end
      @(posedge clk); #1;
      checks++; if (out_valid !== 1'b1 || out_data !== 8'h3D || out_sel !== 2'd3)
         begin errors++; $display("FAIL bp_reload got v=%b data=%h sel=%0d want v=1 data=3d sel=3", out_valid, out_data, out_sel); end
      in_valid = '0;
      @(posedge clk); #1;
   endtask

   task automatic test_reset_mid_packet();
      apply_reset();
      out_ready = 1'b1;
      in_valid = 4'b0100; in_last = 4'b0100; set_data(2, 8'h21);
      @(posedge clk); #1;
      in_last = 4'b0000; set_data(2, 8'h22);
      @(posedge clk); #1;
      checks++; if (out_valid !== 1'b1 || out_sel !== 2'd2 || out_data !== 8'h22 || out_last !== 1'b0)
         begin errors++; $display("FAIL mid_pre got v=%b sel=%0d data=%h last=%b want v=1 sel=2 data=22 last=0", out_valid, out_sel, out_data, out_last); end
      in_valid = '0;
      rst_n = 1'b0;
      #1;
      checks++; if (out_valid !== 1'b0 || out_data !== 8'h00 || out_sel !== 2'd0 || out_last !== 1'b0 || in_ready !== 4'b0000)
         begin errors++; $display("FAIL mid_reset got v=%b data=%h sel=%0d last=%b rdy=%b want all zero", out_valid, out_data, out_sel, out_last, in_ready); end
      @(negedge clk);
      rst_n = 1'b1;
      in_valid = 4'b1101; in_last = 4'b1101;
      set_data(0, 8'h30); set_data(2, 8'h32); set_data(3, 8'h33);
      #1;
      checks++; if (in_ready !== 4'b0001) begin errors++; $display("FAIL mid_after_ready got %b want 0001", in_ready); end
      @(posedge clk); #1;
      checks++; if (out_valid !== 1'b1 || out_sel !== 2'd0 || out_data !== 8'h30)
         begin errors++; $display("FAIL mid_after_out got v=%b sel=%0d data=%h want v=1 sel=0 data=30", out_valid, out_sel, out_data); end
      in_valid = '0;
      @(posedge clk); #1;
   endtask

   initial begin
      test_reset();
      test_single();
      test_round_robin();
      test_fixed_priority();
      test_packet_lock();
      test_backpressure();
      test_reset_mid_packet();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
